switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/switch_allocator_pkg.sv | 22 ++
 rtl/switch_allocator_rr_arb.sv | 44 ++++
 rtl/switch_allocator.sv | 128 ++++++++++++
 tb/tb_switch_allocator.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interact (package)
// Description : Shared router/crossbar types: arity, port index, grant matrix
//               and output lock state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package interact;

    localparam int ARITY    = 5;
    localparam int c_PORT_W = $clog2(ARITY);

    typedef logic [c_PORT_W-1:0]         port_idx_t;
    // [i][o] = 1 connects crossbar input i to output o
    typedef logic [ARITY-1:0][ARITY-1:0] switch_sel_t;

    typedef logic [0:0] lock_state_t;
    localparam lock_state_t c_LOCK_IDLE = 1'b0;
    localparam lock_state_t c_LOCK_HELD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/switch_allocator_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : ARITY-way round-robin arbiter; scans upward from i_ptr with
//               wrap-around and returns the first requester as one-hot + index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb
    import interact::*;
#(
    parameter int ARITY = interact::ARITY
) (
    input  logic [ARITY-1:0] i_req,
    input  port_idx_t        i_ptr,
    output logic [ARITY-1:0] o_gnt,
    output port_idx_t        o_gnt_idx,
    output logic             o_any
);

    int        w_sum;
    port_idx_t w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int k = 0; k < ARITY; k++) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= ARITY) begin
                w_sum = w_sum - ARITY;
            end
            w_idx = port_idx_t'(w_sum);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : switch_allocator
// Description : Per-output wormhole switch allocator with round-robin input
//               selection; drives a registered crossbar grant matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator
    import interact::*;
#(
    parameter int ARITY = interact::ARITY
) (
    input  logic                  clk,
    input  logic                  preset,
    input  logic [ARITY-1:0]      req_valid,
    input  port_idx_t [ARITY-1:0] req_port,
    input  logic [ARITY-1:0]      req_tail,
    input  logic [ARITY-1:0]      flit_fire,
    output switch_sel_t           switch_sel,
    output logic [ARITY-1:0]      grant,
    output logic [ARITY-1:0]      out_busy,
    output logic                  err_bad_port
);

    localparam logic [c_PORT_W:0] c_ARITY_EXT = (c_PORT_W + 1)'(ARITY);

    logic [ARITY-1:0] w_col [ARITY];
    logic [ARITY-1:0] w_bad;
    logic             r_err;

    generate
        for (genvar gi = 0; gi < ARITY; gi++) begin : g_in
            assign w_bad[gi] = req_valid[gi] && ({1'b0, req_port[gi]} >= c_ARITY_EXT);
            assign grant[gi] = |switch_sel[gi];
            for (genvar go = 0; go < ARITY; go++) begin : g_cell
                assign switch_sel[gi][go] = w_col[go][gi];
            end
        end

        for (genvar go = 0; go < ARITY; go++) begin : g_out
            lock_state_t      r_state;
            lock_state_t      w_state_nxt;
            port_idx_t        r_owner;
            port_idx_t        w_owner_nxt;
            port_idx_t        r_rr;
            port_idx_t        w_rr_nxt;
            logic [ARITY-1:0] r_col;
            logic [ARITY-1:0] w_col_nxt;
            logic [ARITY-1:0] w_req;
            logic [ARITY-1:0] w_gnt;
            port_idx_t        w_gnt_idx;
            logic             w_any;

            // Inputs already holding an output are not eligible elsewhere
            for (genvar gi = 0; gi < ARITY; gi++) begin : g_req
                assign w_req[gi] = req_valid[gi] && (req_port[gi] == port_idx_t'(go))
                                   && !grant[gi];
            end

            rr_arb #(
                .ARITY (ARITY)
            ) u_arb (
                .i_req     (w_req),
                .i_ptr     (r_rr),
                .o_gnt     (w_gnt),
                .o_gnt_idx (w_gnt_idx),
                .o_any     (w_any)
            );

            always_comb begin
                w_state_nxt = r_state;
                w_owner_nxt = r_owner;
                w_rr_nxt    = r_rr;
                w_col_nxt   = r_col;
                case (r_state)
                    c_LOCK_IDLE: begin
                        if (w_any) begin
                            w_state_nxt = c_LOCK_HELD;
                            w_owner_nxt = w_gnt_idx;
                            w_col_nxt   = w_gnt;
                            w_rr_nxt    = (w_gnt_idx == port_idx_t'(ARITY - 1)) ? '0
                                                                                : w_gnt_idx + 1'b1;
                        end
                    end
                    c_LOCK_HELD: begin
                        if (flit_fire[r_owner] && req_tail[r_owner]) begin
                            w_state_nxt = c_LOCK_IDLE;
                            w_col_nxt   = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = c_LOCK_IDLE;
                        w_col_nxt   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (preset) begin
                    r_state <= c_LOCK_IDLE;
                    r_owner <= '0;
                    r_rr    <= '0;
                    r_col   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_owner <= w_owner_nxt;
                    r_rr    <= w_rr_nxt;
                    r_col   <= w_col_nxt;
                end
            end

            assign w_col[go]    = r_col;
            assign out_busy[go] = |r_col;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (preset) begin
            r_err <= 1'b0;
        end else if (|w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_bad_port = r_err;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_allocator
// Description : Self-checking bench for switch_allocator against a behavioural
//               owner/pointer model, directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
    import interact::*;

    localparam int A  = interact::ARITY;
    localparam int VW = A * A + 2 * A + 1;

    logic                clk = 1'b0;
    logic                preset;
    logic [A-1:0]        req_valid;
    port_idx_t [A-1:0]   req_port;
    logic [A-1:0]        req_tail;
    logic [A-1:0]        flit_fire;
    switch_sel_t         switch_sel;
    logic [A-1:0]        grant;
    logic [A-1:0]        out_busy;
    logic                err_bad_port;

    int checks = 0;
    int errors = 0;

    // Model state: owner input per output (-1 = idle), pointer, sticky error
    int m_owner [A];
    int m_rr    [A];
    bit m_err;

    switch_allocator #(.ARITY(A)) dut (
        .clk          (clk),
        .preset       (preset),
        .req_valid    (req_valid),
        .req_port     (req_port),
        .req_tail     (req_tail),
        .flit_fire    (flit_fire),
        .switch_sel   (switch_sel),
        .grant        (grant),
        .out_busy     (out_busy),
        .err_bad_port (err_bad_port)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int nown [A];
        bit held [A];
        if (preset) begin
            for (int o = 0; o < A; o++) begin
                m_owner[o] = -1;
                m_rr[o]    = 0;
            end
            m_err = 1'b0;
            return;
        end
        for (int i = 0; i < A; i++) held[i] = 1'b0;
        for (int o = 0; o < A; o++) if (m_owner[o] >= 0) held[m_owner[o]] = 1'b1;
        for (int o = 0; o < A; o++) begin
            nown[o] = m_owner[o];
            if (m_owner[o] < 0) begin
                for (int k = 0; k < A; k++) begin
                    int i;
                    i = (m_rr[o] + k) % A;
                    if (req_valid[i] && int'(req_port[i]) == o && !held[i]) begin
                        nown[o] = i;
                        m_rr[o] = (i + 1) % A;
                        break;
                    end
                end
            end else if (flit_fire[m_owner[o]] && req_tail[m_owner[o]]) begin
                nown[o] = -1;
            end
        end
        for (int o = 0; o < A; o++) m_owner[o] = nown[o];
        for (int i = 0; i < A; i++) if (req_valid[i] && int'(req_port[i]) >= A) m_err = 1'b1;
    endtask

    function automatic logic [VW-1:0] model_vec();
        switch_sel_t  s = '0;
        logic [A-1:0] g = '0;
        logic [A-1:0] b = '0;
        for (int o = 0; o < A; o++) begin
            if (m_owner[o] >= 0) begin
                s[m_owner[o]][o] = 1'b1;
                g[m_owner[o]]    = 1'b1;
                b[o]             = 1'b1;
            end
        end
        return {s, g, b, m_err};
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_port  = '0;
        req_tail  = '0;
        flit_fire = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        preset = 1'b1;
        tick();
        preset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        preset = 1'b1;
        tick();
        checks++;
        if (switch_sel !== '0 || grant !== '0 || out_busy !== '0 || err_bad_port !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%h grant=%b busy=%b err=%b, want all zero",
                     switch_sel, grant, out_busy, err_bad_port);
        end
        // Reset wins over simultaneous requests
        req_valid = 5'b00011;
        req_port[0] = 3'd2;
        req_port[1] = 3'd3;
        tick();
        checks++;
        if (switch_sel !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL reset_priority: sel=%h grant=%b, want zero", switch_sel, grant);
        end
        preset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_grant();
        switch_sel_t exp_s;
        do_reset();
        req_valid[2] = 1'b1;
        req_port[2]  = 3'd4;
        tick();
        exp_s = '0;
        exp_s[2][4] = 1'b1;
        checks++;
        if (switch_sel !== exp_s || grant !== 5'b00100 || out_busy !== 5'b10000) begin
            errors++;
            $display("FAIL single_grant: sel=%h grant=%b busy=%b, want sel=%h grant=00100 busy=10000",
                     switch_sel, grant, out_busy, exp_s);
        end
        flit_fire[2] = 1'b1;
        req_tail[2]  = 1'b1;
        tick();
        checks++;
        if (switch_sel !== '0 || out_busy !== '0) begin
            errors++;
            $display("FAIL single_release: sel=%h busy=%b, want zero", switch_sel, out_busy);
        end
        // Pointer now 3: input 3 must beat input 0
        clear_inputs();
        req_valid = 5'b01001;
        req_port[0] = 3'd4;
        req_port[3] = 3'd4;
        tick();
        checks++;
        if (switch_sel[3][4] !== 1'b1 || switch_sel[0][4] !== 1'b0) begin
            errors++;
            $display("FAIL rr_pointer: sel[3][4]=%b sel[0][4]=%b, want 1 and 0",
                     switch_sel[3][4], switch_sel[0][4]);
        end
        checks++;
        if ({switch_sel, grant, out_busy, err_bad_port} !== model_vec()) begin
            errors++;
            $display("FAIL rr_pointer_model: dut=%h exp=%h",
                     {switch_sel, grant, out_busy, err_bad_port}, model_vec());
        end
    endtask

    task automatic test_rr_order();
        int ins [3] = '{0, 1, 3};
        int sent [A];
        int order [$];
        int last = -1;
        int cur;
        do_reset();
        for (int i = 0; i < A; i++) sent[i] = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            foreach (ins[n]) begin
                req_valid[ins[n]] = (sent[ins[n]] < 2);
                req_port[ins[n]]  = 3'd1;
                req_tail[ins[n]]  = (sent[ins[n]] == 1);
                flit_fire[ins[n]] = (m_owner[1] == ins[n]);
            end
            tick();
            foreach (ins[n]) if (flit_fire[ins[n]]) sent[ins[n]]++;
            checks++;
            if ({switch_sel, grant, out_busy, err_bad_port} !== model_vec()) begin
                errors++;
                $display("FAIL rr_order_model cyc %0d: dut=%h exp=%h", cyc,
                         {switch_sel, grant, out_busy, err_bad_port}, model_vec());
            end
            cur = -1;
            for (int i = 0; i < A; i++) if (switch_sel[i][1] === 1'b1) cur = i;
            if (cur >= 0 && cur != last) order.push_back(cur);
            if (cur >= 0) last = cur;
        end
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 3) begin
            errors++;
            $display("FAIL rr_order: got %0d owners %p, want 0,1,3", order.size(), order);
        end
        clear_inputs();
    endtask

    task automatic test_wormhole();
        do_reset();
        req_valid[0] = 1'b1;
        req_port[0]  = 3'd2;
        tick();
        req_valid    = 5'b00010;
        req_port[1]  = 3'd2;
        req_port[0]  = 3'd3;
        flit_fire    = 5'b01001;
        req_tail     = 5'b01000;
        tick();
        checks++;
        if (switch_sel[0][2] !== 1'b1 || switch_sel[1][2] !== 1'b0 || grant !== 5'b00001) begin
            errors++;
            $display("FAIL wormhole_hold: sel[0][2]=%b sel[1][2]=%b grant=%b, want 1 0 00001",
                     switch_sel[0][2], switch_sel[1][2], grant);
        end
        flit_fire = 5'b00001;
        req_tail  = 5'b00001;
        tick();
        checks++;
        if (switch_sel[0][2] !== 1'b0 || switch_sel[1][2] !== 1'b0 || out_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL wormhole_release: sel[0][2]=%b sel[1][2]=%b busy2=%b, want 0 0 0",
                     switch_sel[0][2], switch_sel[1][2], out_busy[2]);
        end
        flit_fire = '0;
        req_tail  = '0;
        tick();
        checks++;
        if (switch_sel[1][2] !== 1'b1 || grant !== 5'b00010) begin
            errors++;
            $display("FAIL wormhole_next: sel[1][2]=%b grant=%b, want 1 00010",
                     switch_sel[1][2], grant);
        end
        clear_inputs();
    endtask

    task automatic test_anti_diagonal();
        switch_sel_t exp_s = '0;
        do_reset();
        for (int i = 0; i < A; i++) begin
            req_valid[i] = 1'b1;
            req_port[i]  = port_idx_t'(A - 1 - i);
            exp_s[i][A-1-i] = 1'b1;
        end
        tick();
        checks++;
        if (switch_sel !== exp_s || grant !== 5'b11111 || out_busy !== 5'b11111) begin
            errors++;
            $display("FAIL anti_diagonal: sel=%h grant=%b busy=%b, want sel=%h all ones",
                     switch_sel, grant, out_busy, exp_s);
        end
        clear_inputs();
    endtask

    task automatic test_bad_port();
        do_reset();
        req_valid[3] = 1'b1;
        req_port[3]  = 3'd6;
        tick();
        checks++;
        if (grant !== '0 || switch_sel !== '0 || err_bad_port !== 1'b1) begin
            errors++;
            $display("FAIL bad_port_set: grant=%b sel=%h err=%b, want 0 0 1",
                     grant, switch_sel, err_bad_port);
        end
        clear_inputs();
        repeat (3) tick();
        checks++;
        if (err_bad_port !== 1'b1) begin
            errors++;
            $display("FAIL bad_port_sticky: err=%b, want 1", err_bad_port);
        end
        preset = 1'b1;
        tick();
        preset = 1'b0;
        checks++;
        if (err_bad_port !== 1'b0) begin
            errors++;
            $display("FAIL bad_port_clear: err=%b, want 0", err_bad_port);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_valid   = 5'b00101;
        req_port[0] = 3'd1;
        req_port[2] = 3'd3;
        tick();
        checks++;
        if (switch_sel[0][1] !== 1'b1 || switch_sel[2][3] !== 1'b1) begin
            errors++;
            $display("FAIL mid_packet_lock: sel[0][1]=%b sel[2][3]=%b, want 1 1",
                     switch_sel[0][1], switch_sel[2][3]);
        end
        flit_fire = 5'b00101;
        preset    = 1'b1;
        tick();
        checks++;
        if (switch_sel !== '0 || grant !== '0 || out_busy !== '0) begin
            errors++;
            $display("FAIL mid_packet_reset: sel=%h grant=%b busy=%b, want zero",
                     switch_sel, grant, out_busy);
        end
        preset    = 1'b0;
        flit_fire = '0;
        tick();
        checks++;
        if (switch_sel[0][1] !== 1'b1 || switch_sel[2][3] !== 1'b1 || grant !== 5'b00101) begin
            errors++;
            $display("FAIL mid_packet_regrant: sel[0][1]=%b sel[2][3]=%b grant=%b, want 1 1 00101",
                     switch_sel[0][1], switch_sel[2][3], grant);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            preset = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < A; i++) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                req_port[i]  = ($urandom_range(0, 29) == 0) ? port_idx_t'($urandom_range(5, 7))
                                                            : port_idx_t'($urandom_range(0, A - 1));
                req_tail[i]  = ($urandom_range(0, 2) == 0);
                flit_fire[i] = ($urandom_range(0, 1) == 0);
            end
            tick();
            checks++;
            if ({switch_sel, grant, out_busy, err_bad_port} !== model_vec()) begin
                errors++;
                $display("FAIL random_model cyc %0d: dut=%h exp=%h", cyc,
                         {switch_sel, grant, out_busy, err_bad_port}, model_vec());
            end
        end
        preset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        for (int o = 0; o < A; o++) begin
            m_owner[o] = -1;
            m_rr[o]    = 0;
        end
        m_err  = 1'b0;
        preset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_grant();
        test_rr_order();
        test_wormhole();
        test_anti_diagonal();
        test_bad_port();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
